// File: rtl/decoder_pkg.sv
// Shared opcode constants, FSM state encoding and frame field helpers
// for the SPI command frame decoder.
package decoder_pkg;

    localparam logic [7:0] K_CMD_NOP    = 8'h00;
    localparam logic [7:0] K_CMD_READ   = 8'h01;
    localparam logic [7:0] K_CMD_WRITE  = 8'h02;
    localparam logic [7:0] K_CMD_RBURST = 8'h03;
    localparam logic [7:0] K_CMD_WBURST = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_RBURST,
        S_WBURST,
        S_DONE,
        S_ERR
    } cmd_state_t;

    // Frames are passed zero-extended to 64 bits; callers cast the result to the field width.
    function automatic logic [63:0] f_opcode(input logic [63:0] frame,
                                             input int unsigned frame_w,
                                             input int unsigned opcode_w);
        return (frame >> (frame_w - opcode_w)) & ((64'd1 << opcode_w) - 64'd1);
    endfunction

    function automatic logic [63:0] f_addr(input logic [63:0] frame,
                                           input int unsigned addr_w);
        return frame & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cmd_req_slot.sv
// One-entry valid/ready holding register for register-bus requests.
// Contents stay frozen while the request is pending and not yet accepted.
module cmd_req_slot #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_stall
);

    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q & ~i_ready;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (i_load) begin
            valid_d = 1'b1;
            write_d = i_write;
            addr_d  = i_addr;
            wdata_d = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_valid = valid_q;
    assign o_write = write_q;
    assign o_addr  = addr_q;
    assign o_wdata = wdata_q;
    assign o_stall = valid_q & ~i_ready;

endmodule

// File: rtl/cmd_frame_decoder.sv
// SPI frame to register-bus request decoder: single/burst read and write with
// address auto-increment, burst limit and sticky overrun/unknown-opcode flags.
//
// state    | meaning
// IDLE     | waiting for a header frame
// WDATA    | single write header seen, waiting for its data frame
// RBURST   | each further frame issues a read at the next address
// WBURST   | each data frame issues a write at the next address
// DONE     | command complete, frames ignored until CSn high
// ERR      | error seen, frames ignored until CSn high
module cmd_frame_decoder
    import decoder_pkg::*;
#(
    parameter int FRAME_W   = 16,
    parameter int OPCODE_W  = 8,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_spi_csn,
    input  logic [FRAME_W-1:0] i_spi_data,
    input  logic               i_spi_valid,
    output logic               o_req_valid,
    input  logic               i_req_ready,
    output logic               o_req_write,
    output logic [ADDR_W-1:0]  o_req_addr,
    output logic [DATA_W-1:0]  o_req_wdata,
    output logic               o_spi_reset,
    output logic               o_err_unknown,
    output logic               o_err_overrun,
    output logic               o_busy
);

    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    cmd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_unknown_q, err_unknown_d;
    logic              err_overrun_q, err_overrun_d;
    logic              spi_reset_q, spi_reset_d;

    logic                take;
    logic                stall;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   hdr_addr;
    logic                ld;
    logic                ld_write;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_wdata;

    assign take     = i_spi_valid & ~i_spi_csn;
    assign opcode   = OPCODE_W'(f_opcode(64'(i_spi_data), FRAME_W, OPCODE_W));
    assign hdr_addr = ADDR_W'(f_addr(64'(i_spi_data), ADDR_W));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        err_unknown_d = err_unknown_q;
        err_overrun_d = err_overrun_q;
        spi_reset_d   = 1'b0;
        ld            = 1'b0;
        ld_write      = 1'b0;
        ld_addr       = '0;
        ld_wdata      = '0;

        if (i_spi_csn) begin
            state_d       = S_IDLE;
            addr_d        = '0;
            cnt_d         = '0;
            err_unknown_d = 1'b0;
            err_overrun_d = 1'b0;
            spi_reset_d   = 1'b1;
        end else if (take && stall) begin
            // Frame lost: the slot still holds an unaccepted request.
            err_overrun_d = 1'b1;
            state_d       = S_ERR;
        end else if (take) begin
            case (state_q)
                S_IDLE: begin
                    addr_d = hdr_addr;
                    case (opcode)
                        OPCODE_W'(K_CMD_NOP):   state_d = S_DONE;
                        OPCODE_W'(K_CMD_READ): begin
                            ld      = 1'b1;
                            ld_addr = hdr_addr;
                            state_d = S_DONE;
                        end
                        OPCODE_W'(K_CMD_WRITE): state_d = S_WDATA;
                        OPCODE_W'(K_CMD_RBURST): begin
                            ld      = 1'b1;
                            ld_addr = hdr_addr;
                            addr_d  = hdr_addr + ADDR_W'(1);
                            state_d = S_RBURST;
                        end
                        OPCODE_W'(K_CMD_WBURST): state_d = S_WBURST;
                        default: begin
                            err_unknown_d = 1'b1;
                            state_d       = S_ERR;
                        end
                    endcase
                end
                S_WDATA: begin
                    ld       = 1'b1;
                    ld_write = 1'b1;
                    ld_addr  = addr_q;
                    ld_wdata = i_spi_data[DATA_W-1:0];
                    state_d  = S_DONE;
                end
                S_RBURST, S_WBURST: begin
                    if ((MAX_BURST != 0) && (cnt_q == CNT_W'(MAX_BURST))) begin
                        err_overrun_d = 1'b1;
                        state_d       = S_ERR;
                    end else begin
                        ld       = 1'b1;
                        ld_write = (state_q == S_WBURST);
                        ld_addr  = addr_q;
                        ld_wdata = (state_q == S_WBURST) ? i_spi_data[DATA_W-1:0] : '0;
                        addr_d   = addr_q + ADDR_W'(1);
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            err_unknown_q <= 1'b0;
            err_overrun_q <= 1'b0;
            spi_reset_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            err_unknown_q <= err_unknown_d;
            err_overrun_q <= err_overrun_d;
            spi_reset_q   <= spi_reset_d;
        end
    end

    cmd_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (ld),
        .i_write (ld_write),
        .i_addr  (ld_addr),
        .i_wdata (ld_wdata),
        .i_ready (i_req_ready),
        .o_valid (o_req_valid),
        .o_write (o_req_write),
        .o_addr  (o_req_addr),
        .o_wdata (o_req_wdata),
        .o_stall (stall)
    );

    assign o_spi_reset   = spi_reset_q;
    assign o_err_unknown = err_unknown_q;
    assign o_err_overrun = err_overrun_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule
